// File: rtl/mem_bus_responder.sv
// Word-addressed RAM responder for the CPU MEM-stage bus: one access at a time,
// programmable wait states, outputs zeroed when not acknowledging (OR-able bus).
//
// state  | meaning
// IDLE   | waiting for cs_ = 0 and as_ = 0; request fields latched on accept
// WAIT   | wait-state countdown; enters ACK at the edge where the counter is 0
// ACK    | rdy_ low for this single cycle, read data valid; always back to IDLE
module mem_bus_responder #(
    parameter int INDEX_W     = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        cs_,
    input  logic        as_,
    input  logic        rw,
    input  logic [29:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rdy_
);

    localparam int         DEPTH    = 2 ** INDEX_W;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic       RW_READ  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t               r_state;
    logic [3:0]           r_cnt;
    logic [INDEX_W-1:0]   r_idx;
    logic                 r_rw;
    logic [31:0]          r_wdata;
    logic [31:0]          r_rd_data;
    logic                 r_rdy_n;
    logic [31:0]          r_mem [DEPTH];

    logic                 w_req;
    logic                 w_enter_ack;
    logic [INDEX_W-1:0]   w_idx;
    logic                 w_rw;
    logic [31:0]          w_wdata;
    logic                 w_unused_addr;

    assign w_unused_addr = ^addr[29:INDEX_W];

    assign w_req = !cs_ && !as_;

    // With zero wait states the access completes straight from IDLE, so the
    // live bus fields are used instead of the (not yet written) latches.
    always_comb begin
        w_idx       = r_idx;
        w_rw        = r_rw;
        w_wdata     = r_wdata;
        w_enter_ack = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (WAIT_CYCLES == 0) begin
                    w_idx       = addr[INDEX_W-1:0];
                    w_rw        = rw;
                    w_wdata     = wr_data;
                    w_enter_ack = w_req;
                end
            end
            ST_WAIT: w_enter_ack = (r_cnt == 4'd0);
            default: w_enter_ack = 1'b0;
        endcase
        if (!reset_) begin
            w_enter_ack = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enter_ack && (w_rw != RW_READ)) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_rdy_n   <= 1'b1;
            r_rd_data <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_idx   <= addr[INDEX_W-1:0];
                        r_rw    <= rw;
                        r_wdata <= wr_data;
                        r_cnt   <= CNT_INIT;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= ST_ACK;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_ACK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_enter_ack) begin
                r_rdy_n <= 1'b0;
                if (w_rw == RW_READ) begin
                    r_rd_data <= r_mem[w_idx];
                end
            end else begin
                r_rdy_n   <= 1'b1;
                r_rd_data <= 32'd0;
            end
        end
    end

    assign rd_data = r_rd_data;
    assign rdy_    = r_rdy_n;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: two instances (2 and 0 wait states) checked every
// cycle against an edge-counting transaction model plus directed literal checks.
module tb_mem_bus_responder;

    logic        clk = 1'b0;
    logic        reset_;
    logic        cs_n  [2];
    logic        as_n  [2];
    logic        rw    [2];
    logic [29:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rd    [2];
    logic        rdy_n [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_responder #(.INDEX_W(10), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .reset_(reset_), .cs_(cs_n[0]), .as_(as_n[0]), .rw(rw[0]),
        .addr(addr[0]), .wr_data(wdata[0]), .rd_data(rd[0]), .rdy_(rdy_n[0])
    );

    mem_bus_responder #(.INDEX_W(10), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .reset_(reset_), .cs_(cs_n[1]), .as_(as_n[1]), .rw(rw[1]),
        .addr(addr[1]), .wr_data(wdata[1]), .rd_data(rd[1]), .rdy_(rdy_n[1])
    );

    function automatic int wait_of(int k);
        return (k == 0) ? 2 : 0;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Transaction model: an access accepted at edge n acknowledges at edge
    // n+WAIT, is released at the following edge, and only then can a new one
    // be accepted.
    int          edge_no = 0;
    bit          model_on = 0;
    bit          active   [2];
    int          ack_e    [2];
    logic [9:0]  m_idx    [2];
    logic        m_rw     [2];
    logic [31:0] m_wd     [2];
    logic [31:0] mem      [2][1024];
    bit          known    [2][1024];
    logic        exp_rdy  [2];
    logic [31:0] exp_rd   [2];
    bit          exp_known[2];

    always @(posedge clk) begin
        edge_no++;
        for (int k = 0; k < 2; k++) begin
            if (!reset_) begin
                active[k]    = 0;
                exp_rdy[k]   = 1'b1;
                exp_rd[k]    = 32'd0;
                exp_known[k] = 1;
            end else begin
                if (active[k] && edge_no == ack_e[k] + 1) begin
                    active[k]    = 0;
                    exp_rdy[k]   = 1'b1;
                    exp_rd[k]    = 32'd0;
                    exp_known[k] = 1;
                end else if (!active[k] && !cs_n[k] && !as_n[k]) begin
                    active[k] = 1;
                    ack_e[k]  = edge_no + wait_of(k);
                    m_idx[k]  = addr[k][9:0];
                    m_rw[k]   = rw[k];
                    m_wd[k]   = wdata[k];
                end
                if (active[k] && edge_no == ack_e[k]) begin
                    exp_rdy[k] = 1'b0;
                    if (m_rw[k]) begin
                        exp_rd[k]    = mem[k][m_idx[k]];
                        exp_known[k] = known[k][m_idx[k]];
                    end else begin
                        mem[k][m_idx[k]]   = m_wd[k];
                        known[k][m_idx[k]] = 1;
                        exp_rd[k]          = 32'd0;
                        exp_known[k]       = 1;
                    end
                end
            end
        end
        if (!reset_) model_on = 1;
    end

    always @(negedge clk) begin
        if (model_on) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model rdy_ inst%0d", k), {31'd0, rdy_n[k]}, {31'd0, exp_rdy[k]});
                if (exp_known[k]) chk($sformatf("model rd_data inst%0d", k), rd[k], exp_rd[k]);
            end
        end
    end

    // Called just after an edge; returns just after the edge leaving ACK.
    // Fields are scrambled after capture to show they are ignored.
    task automatic access(int k, logic [29:0] a, logic r, logic [31:0] wd, logic [31:0] lit);
        cs_n[k] = 1'b0; as_n[k] = 1'b0; rw[k] = r; addr[k] = a; wdata[k] = wd;
        @(posedge clk); #1;
        cs_n[k] = 1'b1; as_n[k] = 1'b1; rw[k] = ~r; addr[k] = ~a; wdata[k] = ~wd;
        for (int i = 0; i < wait_of(k); i++) begin
            chk("pre-ack rdy_", {31'd0, rdy_n[k]}, 32'd1);
            @(posedge clk); #1;
        end
        chk("ack rdy_", {31'd0, rdy_n[k]}, 32'd0);
        chk(r ? "ack read data" : "write rd_data zero", rd[k], r ? lit : 32'd0);
        @(posedge clk); #1;
        chk("post-ack rdy_", {31'd0, rdy_n[k]}, 32'd1);
        chk("post-ack rd_data", rd[k], 32'd0);
    endtask

    task automatic hold_read(int k, logic [29:0] a, int cycles, logic [31:0] lit);
        int  per;
        bit  lo;
        per = wait_of(k) + 2;
        cs_n[k] = 1'b0; as_n[k] = 1'b0; rw[k] = 1'b1; addr[k] = a;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            lo = ((i % per) == wait_of(k));
            chk("held rdy_", {31'd0, rdy_n[k]}, lo ? 32'd0 : 32'd1);
            chk(lo ? "held read data" : "held gap rd_data", rd[k], lo ? lit : 32'd0);
        end
        cs_n[k] = 1'b1; as_n[k] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        reset_ = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cs_n[k] = 1'b0; as_n[k] = 1'b0; rw[k] = 1'b0; addr[k] = 30'd0; wdata[k] = 32'd0;
        end

        // reset held 3 cycles with a request present
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                chk("reset rdy_", {31'd0, rdy_n[k]}, 32'd1);
                chk("reset rd_data", rd[k], 32'd0);
            end
        end
        for (int k = 0; k < 2; k++) begin
            cs_n[k] = 1'b1; as_n[k] = 1'b1;
        end
        reset_ = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle rdy_", {31'd0, rdy_n[0]}, 32'd1);

        // write then read
        access(0, 30'h005, 1'b0, 32'hDEADBEEF, 32'd0);
        access(0, 30'h005, 1'b1, 32'd0, 32'hDEADBEEF);

        // aliasing above INDEX_W
        access(0, 30'h00000405, 1'b0, 32'h12345678, 32'd0);
        access(0, 30'h005, 1'b1, 32'd0, 32'h12345678);

        // field capture (scrambled after the request edge inside access)
        access(0, 30'h020, 1'b0, 32'hCAFEF00D, 32'd0);
        access(0, 30'h020, 1'b1, 32'd0, 32'hCAFEF00D);

        // reset abort during WAIT
        access(0, 30'h010, 1'b0, 32'h11111111, 32'd0);
        cs_n[0] = 1'b0; as_n[0] = 1'b0; rw[0] = 1'b0; addr[0] = 30'h010; wdata[0] = 32'hA5A5A5A5;
        @(posedge clk); #1;
        cs_n[0] = 1'b1; as_n[0] = 1'b1;
        @(posedge clk); #1;
        reset_ = 1'b0;
        @(posedge clk); #1;
        reset_ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("abort no rdy_", {31'd0, rdy_n[0]}, 32'd1);
            @(posedge clk); #1;
        end
        access(0, 30'h010, 1'b1, 32'd0, 32'h11111111);

        // request held low through ACK, 2 wait states: one access per 4 cycles
        hold_read(0, 30'h005, 9, 32'h12345678);

        // zero wait states
        access(1, 30'h007, 1'b0, 32'h0BADC0DE, 32'd0);
        access(1, 30'h007, 1'b1, 32'd0, 32'h0BADC0DE);
        hold_read(1, 30'h007, 8, 32'h0BADC0DE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
